sequenciador_motor: RTL and testbench

Soft-start/soft-stop sequencer for the DC motor driver output. Sits between the temperature-control FSM's `motor_on` request and the physical `MOTOR_OUT` pin. It turns the on/off request into a ramped PWM drive, enforces a minimum off-time against short-cycling, and optionally trips a run-time watchdog. It uses the 27 MHz system clock and the existing 1 Hz tick from `divisor_clock`.

---
 rtl/sequenciador_motor.sv | 145 ++++++++++++++
 tb/tb_sequenciador_motor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_motor.sv
// Soft-start/soft-stop sequencer: ramps motor PWM duty on request, enforces a minimum off-time.
// Optional run-time watchdog with FAULT state compiled in when SEQ_WATCHDOG_EN is defined.
module sequenciador_motor #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_DIV  = 1024,
  parameter int RAMP_STEP = 8,
  parameter int MIN_OFF_S = 5,
  parameter int MAX_ON_S  = 120
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_1hz,
  input  logic                motor_req,
  input  logic                fault_clr,
  output logic                motor_pwm,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          state_o,
  output logic                busy,
  output logic                fault
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] DMAX     = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = DMAX - 1'b1;
  localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS+1)'(RAMP_STEP);
  localparam logic [7:0]          OFF_LAST  = 8'(MIN_OFF_S - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLDOFF   = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t              state, state_nx;
  logic [PWM_BITS-1:0] duty_nx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [RW-1:0]       ramp_cnt;
  logic [7:0]          sec_cnt;
  logic                ramping, step, sec_tick;
  logic [PWM_BITS:0]   sum_up;

  assign ramping  = (state == RAMP_UP) || (state == RAMP_DOWN);
  assign step     = ramping && (ramp_cnt == RAMP_LAST);
  assign sec_tick = tick_1hz && ((state == RUN) || (state == HOLDOFF));
  assign sum_up   = {1'b0, duty} + STEP_W;

  always_comb begin
    state_nx = state;
    duty_nx  = duty;
    case (state)
      IDLE: begin
        duty_nx = '0;
        if (motor_req) state_nx = RAMP_UP;
      end
      RAMP_UP: begin
        // Dropping the request wins over a coincident step.
        if (!motor_req) begin
          state_nx = RAMP_DOWN;
        end else if (step) begin
          if (sum_up >= {1'b0, DMAX}) begin
            duty_nx  = DMAX;
            state_nx = RUN;
          end else begin
            duty_nx = sum_up[PWM_BITS-1:0];
          end
        end
      end
      RUN: begin
        duty_nx = DMAX;
        if (!motor_req) begin
          state_nx = RAMP_DOWN;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (tick_1hz && sec_cnt == 8'(MAX_ON_S - 1)) begin
          state_nx = FAULT;
          duty_nx  = '0;
        end
`endif
      end
      RAMP_DOWN: begin
        if (motor_req) begin
          state_nx = RAMP_UP;
        end else if (step) begin
          if ({1'b0, duty} <= STEP_W) begin
            duty_nx  = '0;
            state_nx = HOLDOFF;
          end else begin
            duty_nx = duty - STEP_W[PWM_BITS-1:0];
          end
        end
      end
      HOLDOFF: begin
        duty_nx = '0;
        if (tick_1hz && sec_cnt == OFF_LAST) state_nx = IDLE;
      end
`ifdef SEQ_WATCHDOG_EN
      FAULT: begin
        duty_nx = '0;
        if (fault_clr && !motor_req) state_nx = HOLDOFF;
      end
`endif
      default: begin
        state_nx = IDLE;
        duty_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      duty      <= '0;
      ramp_cnt  <= '0;
      sec_cnt   <= '0;
      pwm_cnt   <= '0;
      motor_pwm <= 1'b0;
    end else begin
      state     <= state_nx;
      duty      <= duty_nx;
      motor_pwm <= (pwm_cnt < duty);
      pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      if (state_nx != state || !ramping || step) ramp_cnt <= '0;
      else                                       ramp_cnt <= ramp_cnt + 1'b1;
      // A tick in the transition cycle is dropped by the clear.
      if (state_nx != state) sec_cnt <= '0;
      else if (sec_tick)     sec_cnt <= sec_cnt + 1'b1;
    end
  end

  assign state_o = state;
  assign busy    = (state != IDLE);

`ifdef SEQ_WATCHDOG_EN
  assign fault = (state == FAULT);
`else
  logic unused_cfg;
  assign unused_cfg = ^{fault_clr, 8'(MAX_ON_S)};
  assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_sequenciador_motor.sv
// Directed bench for sequenciador_motor with a queue of expected results checked in order.
module tb_sequenciador_motor;
  logic       clk, rst_n, tick_1hz, motor_req, fault_clr;
  logic       motor_pwm, busy, fault;
  logic [7:0] duty;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  sequenciador_motor #(
    .PWM_BITS(8), .RAMP_DIV(4), .RAMP_STEP(64), .MIN_OFF_S(2), .MAX_ON_S(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .motor_req(motor_req),
    .fault_clr(fault_clr), .motor_pwm(motor_pwm), .duty(duty),
    .state_o(state_o), .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    step();
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n;
    n = 0;
    push(tag, 32'(target));
    while (state_o !== target && n < budget) begin
      step();
      n++;
    end
    chk(32'(state_o));
  endtask

  initial begin
    int zeros;
    logic [7:0] up_vals [4];
    up_vals = '{8'd64, 8'd128, 8'd192, 8'd255};

    rst_n = 1'b0; motor_req = 1'b1; tick_1hz = 1'b0; fault_clr = 1'b0;
    repeat (3) step();
    push("rst_duty", 0);  chk(32'(duty));
    push("rst_pwm", 0);   chk(32'(motor_pwm));
    push("rst_state", 0); chk(32'(state_o));
    push("rst_busy", 0);  chk(32'(busy));
    push("rst_fault", 0); chk(32'(fault));

    motor_req = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    push("idle_hold", 0); chk(32'(state_o));

    // Ramp-up: steps land 4/8/12/16 clocks after entry.
    motor_req = 1'b1;
    push("up_entry_state", 1); push("up_entry_duty", 0);
    step();
    chk(32'(state_o)); chk(32'(duty));
    for (int k = 0; k < 4; k++) begin
      push($sformatf("up_pre%0d", k), (k == 0) ? 0 : 32'(up_vals[k-1]));
      push($sformatf("up_step%0d", k), 32'(up_vals[k]));
      repeat (3) step();
      chk(32'(duty));
      step();
      chk(32'(duty));
    end
    push("run_state", 2); chk(32'(state_o));
    step();
    zeros = 0;
    for (int i = 0; i < 260; i++) begin
      if (motor_pwm !== 1'b1) zeros++;
      step();
    end
    push("run_pwm_const1", 0); chk(32'(zeros));

`ifdef SEQ_WATCHDOG_EN
    pulse_tick();
    pulse_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    push("wd_state", 5); chk(32'(state_o));
    push("wd_fault", 1); chk(32'(fault));
    push("wd_duty", 0);  chk(32'(duty));
    step();
    push("wd_pwm", 0);   chk(32'(motor_pwm));
    fault_clr = 1'b1;
    repeat (2) step();
    push("wd_clr_req_hi", 5); chk(32'(state_o));
    motor_req = 1'b0;
    step();
    fault_clr = 1'b0;
    push("wd_exit_holdoff", 4); chk(32'(state_o));
`else
    for (int i = 0; i < 10; i++) pulse_tick();
    push("nowd_state", 2); chk(32'(state_o));
    push("nowd_fault", 0); chk(32'(fault));
    motor_req = 1'b0;
    step();
    push("down_state", 3); chk(32'(state_o));
    wait_state(3'd4, 40, "reach_holdoff");
`endif

    // Hold-off ignores requests until MIN_OFF_S ticks have been counted.
    motor_req = 1'b1; tick_1hz = 1'b1;
    step();
    motor_req = 1'b0; tick_1hz = 1'b0;
    push("holdoff_1tick", 4); chk(32'(state_o));
    repeat (3) step();
    push("holdoff_wait", 4); chk(32'(state_o));
    push("holdoff_duty", 0); chk(32'(duty));
    motor_req = 1'b1; tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    push("holdoff_exit", 0); chk(32'(state_o));
    step();
    push("restart_up", 1); chk(32'(state_o));

    // Reversal at duty 128.
    repeat (8) step();
    push("rev_at128", 128); chk(32'(duty));
    motor_req = 1'b0;
    step();
    push("rev_down_state", 3); chk(32'(state_o));
    push("rev_down_keep", 128); chk(32'(duty));
    repeat (4) step();
    push("rev_down_64", 64); chk(32'(duty));
    motor_req = 1'b1;
    step();
    push("rev_up_state", 1); chk(32'(state_o));
    repeat (4) step();
    push("rev_up_128", 128); chk(32'(duty));

    // Asynchronous reset between edges during RUN.
    wait_state(3'd2, 40, "rerun");
    repeat (3) step();
    push("pre_rst_pwm", 1); chk(32'(motor_pwm));
    #3 rst_n = 1'b0;
    #1;
    push("arst_pwm", 0);   chk(32'(motor_pwm));
    push("arst_state", 0); chk(32'(state_o));
    push("arst_duty", 0);  chk(32'(duty));
    push("arst_busy", 0);  chk(32'(busy));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
